// File: rtl/spram_arbiter.sv
// spram_arbiter: shares one single-ported SPRAM bank between port A (CPU data
// path, default priority) and port B (loader / debug master). Grants are
// combinational; a starvation counter forces a B slot after MAX_WAIT
// consecutive losses. Read data is a passthrough qualified by per-port rvalid.
module spram_arbiter #(
  parameter int AW       = 14,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  input  logic          a_write,
  input  logic [3:0]    a_wmask,
  input  logic [31:0]   a_wdata,
  input  logic [AW-1:0] a_addr,
  output logic          a_ready,
  output logic          a_rvalid,
  output logic [31:0]   a_rdata,
  input  logic          b_valid,
  input  logic          b_write,
  input  logic [3:0]    b_wmask,
  input  logic [31:0]   b_wdata,
  input  logic [AW-1:0] b_addr,
  output logic          b_ready,
  output logic          b_rvalid,
  output logic [31:0]   b_rdata,
  output logic          mem_valid,
  output logic          mem_write,
  output logic [3:0]    mem_wmask,
  output logic [31:0]   mem_wdata,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_rdata
);

  // Counter must hold 0..MAX_WAIT; keep at least one bit when MAX_WAIT is 0.
  localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

  logic [WCW-1:0] wait_cnt_r;
  logic           q_rd_a_r;
  logic           q_rd_b_r;
  logic           force_b_s;
  logic           grant_a_s;
  logic           grant_b_s;

  // Same-cycle grant decision; reset gates both grants off.
  always_comb begin
    force_b_s = b_valid & (wait_cnt_r == WAIT_MAX);
    grant_b_s = ~rst & b_valid & (~a_valid | force_b_s);
    grant_a_s = ~rst & a_valid & ~grant_b_s;
    a_ready   = grant_a_s;
    b_ready   = grant_b_s;
    mem_valid = grant_a_s | grant_b_s;
  end

  // Memory request mux; idle cycles drive a harmless read with no byte enables.
  always_comb begin
    if (grant_b_s) begin
      mem_write = b_write;
      mem_wmask = b_wmask;
      mem_wdata = b_wdata;
      mem_addr  = b_addr;
    end else if (grant_a_s) begin
      mem_write = a_write;
      mem_wmask = a_wmask;
      mem_wdata = a_wdata;
      mem_addr  = a_addr;
    end else begin
      mem_write = 1'b0;
      mem_wmask = 4'h0;
      mem_wdata = a_wdata;
      mem_addr  = a_addr;
    end
  end

  // Count consecutive cycles B has been refused; saturates so force_b holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= '0;
    end else if (grant_b_s | ~b_valid) begin
      wait_cnt_r <= '0;
    end else if (wait_cnt_r != WAIT_MAX) begin
      wait_cnt_r <= wait_cnt_r + WCW'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Remember which port issued a read so its data is flagged one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_rd_a_r <= 1'b0;
      q_rd_b_r <= 1'b0;
    end else begin
      q_rd_a_r <= grant_a_s & ~a_write;
      q_rd_b_r <= grant_b_s & ~b_write;
    end
  end

  // Responses: shared read data, qualified by each port's own rvalid.
  always_comb begin
    a_rvalid = q_rd_a_r;
    b_rvalid = q_rd_b_r;
    a_rdata  = mem_rdata;
    b_rdata  = mem_rdata;
  end

endmodule

// File: tb/tb_spram_arbiter.sv
// Self-checking bench for spram_arbiter: directed scenarios followed by
// constrained-random traffic, compared each cycle against a behavioural model
// (loss counters as integers, expected memory as an associative array).
module tb_spram_arbiter;

  localparam int AW = 14;

  logic          clk;
  logic          rst;
  logic          a_valid, a_write, b_valid, b_write;
  logic [3:0]    a_wmask, b_wmask;
  logic [31:0]   a_wdata, b_wdata;
  logic [AW-1:0] a_addr, b_addr;

  // Outputs of the MAX_WAIT=4 instance
  logic          a_ready, a_rvalid, b_ready, b_rvalid;
  logic [31:0]   a_rdata, b_rdata;
  logic          mem_valid, mem_write;
  logic [3:0]    mem_wmask;
  logic [31:0]   mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;

  // Outputs of the MAX_WAIT=0 instance (grant/response behaviour only)
  logic          a_ready0, a_rvalid0, b_ready0, b_rvalid0;
  logic [31:0]   a_rdata0, b_rdata0;
  logic          mem_valid0, mem_write0;
  logic [3:0]    mem_wmask0;
  logic [31:0]   mem_wdata0;
  logic [AW-1:0] mem_addr0;
  logic [31:0]   mem_rdata0;

  int tests = 0;
  int fails = 0;

  spram_arbiter #(.AW(AW), .MAX_WAIT(4)) u_arb4 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_write(a_write), .a_wmask(a_wmask), .a_wdata(a_wdata), .a_addr(a_addr),
    .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_write(b_write), .b_wmask(b_wmask), .b_wdata(b_wdata), .b_addr(b_addr),
    .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_valid(mem_valid), .mem_write(mem_write), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  spram_arbiter #(.AW(AW), .MAX_WAIT(0)) u_arb0 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_write(a_write), .a_wmask(a_wmask), .a_wdata(a_wdata), .a_addr(a_addr),
    .a_ready(a_ready0), .a_rvalid(a_rvalid0), .a_rdata(a_rdata0),
    .b_valid(b_valid), .b_write(b_write), .b_wmask(b_wmask), .b_wdata(b_wdata), .b_addr(b_addr),
    .b_ready(b_ready0), .b_rvalid(b_rvalid0), .b_rdata(b_rdata0),
    .mem_valid(mem_valid0), .mem_write(mem_write0), .mem_wmask(mem_wmask0),
    .mem_wdata(mem_wdata0), .mem_addr(mem_addr0), .mem_rdata(mem_rdata0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata0 = 32'h0;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] wd,
                                        input logic [3:0] m);
    logic [31:0] bm;
    bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    return (old_v & ~bm) | (wd & bm);
  endfunction

  // Memory environment: unwritten words read back as addr ^ 0xA5A5A5A5.
  logic [31:0] env_mem [int];
  always @(posedge clk) begin
    if (mem_valid) begin
      if (mem_write) begin
        env_mem[int'(mem_addr)] = merge(env_mem.exists(int'(mem_addr)) ?
            env_mem[int'(mem_addr)] : (32'(mem_addr) ^ 32'hA5A5A5A5), mem_wdata, mem_wmask);
      end else begin
        mem_rdata <= env_mem.exists(int'(mem_addr)) ? env_mem[int'(mem_addr)]
                                                    : (32'(mem_addr) ^ 32'hA5A5A5A5);
      end
    end
  end

  // Reference model state
  logic [31:0] ref_mem [int];
  int   loss4 = 0, loss0 = 0;
  bit   rva4 = 0, rvb4 = 0, rva0 = 0, rvb0 = 0;
  logic [31:0] exp_rd = 32'h0;
  bit   last_ga, last_gb;
  logic [31:0] seen_b_rdata = 32'h0;

  function automatic logic [31:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : (32'(a) ^ 32'hA5A5A5A5);
  endfunction

  // B wins if A is idle or B has already lost MAX_WAIT times in a row.
  function automatic bit model_gb(input int loss, input int mw, input logic r,
                                  input logic av, input logic bv);
    return !r && bv && (!av || loss >= mw);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock: apply inputs, check outputs mid-cycle, advance the model.
  task automatic step(input logic r,
                      input logic av, input logic aw, input logic [3:0] am,
                      input logic [31:0] ad, input logic [AW-1:0] aa,
                      input logic bv, input logic bw, input logic [3:0] bm,
                      input logic [31:0] bd, input logic [AW-1:0] ba);
    bit ga4, gb4, ga0, gb0;
    rst = r;
    a_valid = av; a_write = aw; a_wmask = am; a_wdata = ad; a_addr = aa;
    b_valid = bv; b_write = bw; b_wmask = bm; b_wdata = bd; b_addr = ba;
    #1;
    gb4 = model_gb(loss4, 4, r, av, bv);
    ga4 = !r && av && !gb4;
    gb0 = model_gb(loss0, 0, r, av, bv);
    ga0 = !r && av && !gb0;
    chk("a_ready", a_ready, ga4);
    chk("b_ready", b_ready, gb4);
    chk("mem_valid", mem_valid, ga4 | gb4);
    chk("a_rvalid", a_rvalid, rva4);
    chk("b_rvalid", b_rvalid, rvb4);
    if (rva4) chk("a_rdata", a_rdata, exp_rd);
    if (rvb4) begin
      chk("b_rdata", b_rdata, exp_rd);
      seen_b_rdata = b_rdata;
    end
    if (ga4 || gb4) begin
      chk("mem_write", mem_write, gb4 ? bw : aw);
      chk("mem_addr", mem_addr, gb4 ? ba : aa);
      if (gb4 ? bw : aw) begin
        chk("mem_wmask", mem_wmask, gb4 ? bm : am);
        chk("mem_wdata", mem_wdata, gb4 ? bd : ad);
      end
    end else begin
      chk("idle_write", mem_write, 1'b0);
      chk("idle_wmask", mem_wmask, 4'h0);
    end
    chk("mw0_a_ready", a_ready0, ga0);
    chk("mw0_b_ready", b_ready0, gb0);
    chk("mw0_a_rvalid", a_rvalid0, rva0);
    chk("mw0_b_rvalid", b_rvalid0, rvb0);
    last_ga = ga4;
    last_gb = gb4;
    @(posedge clk);
    rva4 = ga4 && !aw;
    rvb4 = gb4 && !bw;
    rva0 = ga0 && !aw;
    rvb0 = gb0 && !bw;
    if (rva4) exp_rd = ref_rd(aa);
    if (rvb4) exp_rd = ref_rd(ba);
    if (ga4 && aw) ref_mem[int'(aa)] = merge(ref_rd(aa), ad, am);
    if (gb4 && bw) ref_mem[int'(ba)] = merge(ref_rd(ba), bd, bm);
    if (r || gb4 || !bv) loss4 = 0; else if (loss4 < 4) loss4++;
    if (r || gb0 || !bv) loss0 = 0; else if (loss0 < 0) loss0++;
    @(negedge clk);
  endtask

  initial begin
    int first_b;
    rst = 1'b1;
    a_valid = 1'b0; a_write = 1'b0; a_wmask = 4'h0; a_wdata = 32'h0; a_addr = '0;
    b_valid = 1'b0; b_write = 1'b0; b_wmask = 4'h0; b_wdata = 32'h0; b_addr = '0;
    @(negedge clk);

    // Reset, then A-only read stream 0x10..0x13
    step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 14'h0, 1'b0, 1'b0, 4'h0, 32'h0, 14'h0);
    step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 14'h0, 1'b0, 1'b0, 4'h0, 32'h0, 14'h0);
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 14'(16 + i), 1'b0, 1'b0, 4'h0, 32'h0, 14'h0);
    step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 14'h0, 1'b0, 1'b0, 4'h0, 32'h0, 14'h0);

    // B write then read of 0x100 with A idle
    step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 14'h0, 1'b1, 1'b1, 4'hF, 32'hDEADBEEF, 14'h100);
    step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 14'h0, 1'b1, 1'b0, 4'h0, 32'h0, 14'h100);
    step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 14'h0, 1'b0, 1'b0, 4'h0, 32'h0, 14'h0);
    chk("b_read_back", seen_b_rdata, 32'hDEADBEEF);

    // Starvation: A streams, B read held from cycle 0 until accepted
    first_b = -1;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 14'(32 + i), first_b < 0, 1'b0, 4'h0, 32'h0, 14'h200);
      if (last_gb && first_b < 0) first_b = i;
    end
    chk("starve_first_b", 32'(first_b), 32'd4);

    // Both valid continuously: the MAX_WAIT=0 copy grants B every cycle
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 14'h40, 1'b1, 1'b0, 4'h0, 32'h0, 14'(64 + i));
    step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 14'h0, 1'b0, 1'b0, 4'h0, 32'h0, 14'h0);

    // Byte-mask write from A, then read it back
    step(1'b0, 1'b1, 1'b1, 4'h6, 32'h11223344, 14'h20, 1'b0, 1'b0, 4'h0, 32'h0, 14'h0);
    step(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 14'h20, 1'b0, 1'b0, 4'h0, 32'h0, 14'h0);
    step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 14'h0, 1'b0, 1'b0, 4'h0, 32'h0, 14'h0);

    // Reset mid-traffic: read granted, then rst for three cycles with requests held
    step(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 14'h30, 1'b1, 1'b0, 4'h0, 32'h0, 14'h31);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 14'h30, 1'b1, 1'b0, 4'h0, 32'h0, 14'h31);
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 14'h30, 1'b1, 1'b0, 4'h0, 32'h0, 14'h31);

    // Random traffic obeying the hold-until-accepted rule
    for (int n = 0; n < 400; n++) begin
      logic r, av, aw, bv, bw;
      logic [3:0] am, bm;
      logic [31:0] ad, bd;
      logic [AW-1:0] aa, ba;
      r = ($urandom_range(0, 39) == 0);
      if (!a_valid || last_ga) begin
        av = ($urandom_range(0, 3) != 0); aw = $urandom_range(0, 1);
        am = 4'($urandom); ad = $urandom; aa = 14'($urandom_range(0, 15));
      end else begin
        av = a_valid; aw = a_write; am = a_wmask; ad = a_wdata; aa = a_addr;
      end
      if (!b_valid || last_gb) begin
        bv = ($urandom_range(0, 1) != 0); bw = $urandom_range(0, 1);
        bm = 4'($urandom); bd = $urandom; ba = 14'($urandom_range(0, 15));
      end else begin
        bv = b_valid; bw = b_write; bm = b_wmask; bd = b_wdata; ba = b_addr;
      end
      step(r, av, aw, am, ad, aa, bv, bw, bm, bd, ba);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
